// File: rtl/hash_table_scan_pkg.sv
// rtl/hash_table_scan_pkg.sv - shared scan FSM encoding, log2 helper and default sizing
package hash_table_scan_pkg;

    // Defaults shared with the upstream hash stage
    localparam int DEF_DATA_INDEX_WIDTH = 32;
    localparam int DEF_BIT_ON_TAILS     = 7;
    localparam int DEF_MIN_OCCURR       = 1;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RD   = 3'd1,
        S_CHK  = 3'd2,
        S_EMIT = 3'd3,
        S_DONE = 3'd4
    } scan_state_t;

    // Ceiling log2, usable in constant expressions
    function automatic int hts_log2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/hash_occurr_ram.sv
// rtl/hash_occurr_ram.sv - dual-array hash/occurrence table, one write port, registered write-first read
module hash_occurr_ram
    import hash_table_scan_pkg::*;
#(
    parameter int DW         = DEF_DATA_INDEX_WIDTH,
    parameter int AW         = DEF_BIT_ON_TAILS,
    parameter int MIN_OCCURR = DEF_MIN_OCCURR
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_we,
    input  logic [AW:0]   i_waddr,
    input  logic [DW-1:0] i_wr_hash,
    input  logic [DW-1:0] i_wr_occ,
    input  logic [AW:0]   i_rd_addr,
    output logic [DW-1:0] o_rd_hash,
    output logic [DW-1:0] o_rd_occ,
    output logic [AW:0]   o_qual_cnt
);

    localparam int DEPTH = 1 << AW;
    localparam logic [AW:0] CNT_ONE = 1;

    logic [DW-1:0] r_hash [DEPTH];
    logic [DW-1:0] r_occ  [DEPTH];
    logic [DW-1:0] r_rd_hash;
    logic [DW-1:0] r_rd_occ;
    logic          w_wr_ok;
    logic          w_rd_ok;
    logic          w_fwd;
    logic [AW:0]   w_cnt;

    // The top address bit selects the out-of-range half: reads return zero, writes vanish
    assign w_wr_ok = i_we && !i_waddr[AW];
    assign w_rd_ok = !i_rd_addr[AW];
    assign w_fwd   = w_wr_ok && (i_waddr == i_rd_addr);

    // Table storage; reset wipes every entry so a new data block starts empty
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_hash[i] <= '0;
                r_occ[i]  <= '0;
            end
        end else if (w_wr_ok) begin
            r_hash[i_waddr[AW-1:0]] <= i_wr_hash;
            r_occ[i_waddr[AW-1:0]]  <= i_wr_occ;
        end
    end

    // Registered read port; a same-edge write to the read address is forwarded
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_hash <= '0;
            r_rd_occ  <= '0;
        end else if (!w_rd_ok) begin
            r_rd_hash <= '0;
            r_rd_occ  <= '0;
        end else if (w_fwd) begin
            r_rd_hash <= i_wr_hash;
            r_rd_occ  <= i_wr_occ;
        end else begin
            r_rd_hash <= r_hash[i_rd_addr[AW-1:0]];
            r_rd_occ  <= r_occ[i_rd_addr[AW-1:0]];
        end
    end

    // Live count of qualifying entries; one extra bit so a full table cannot wrap
    always_comb begin
        w_cnt = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (r_occ[i] >= DW'(MIN_OCCURR)) begin
                w_cnt = w_cnt + CNT_ONE;
            end
        end
    end

    assign o_rd_hash  = r_rd_hash;
    assign o_rd_occ   = r_rd_occ;
    assign o_qual_cnt = w_cnt;

endmodule

// File: rtl/hash_table_scan.sv
// rtl/hash_table_scan.sv - hash/occurrence table with emit scan; HASH_SCAN_CLEAR_EN zeroes visited entries
module hash_table_scan
    import hash_table_scan_pkg::*;
#(
    parameter int DATA_INDEX_WIDTH = DEF_DATA_INDEX_WIDTH,
    parameter int BIT_ON_TAILS     = DEF_BIT_ON_TAILS,
    parameter int MIN_OCCURR       = DEF_MIN_OCCURR
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [BIT_ON_TAILS:0]       HashOccurrAddr,
    output logic [DATA_INDEX_WIDTH-1:0] HashValue,
    output logic [DATA_INDEX_WIDTH-1:0] OccurrValue,
    input  logic                        WrEn,
    input  logic [DATA_INDEX_WIDTH-1:0] NewHashValue,
    input  logic [DATA_INDEX_WIDTH-1:0] NewOccurrValue,
    input  logic                        complete,
    output logic                        busy,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [BIT_ON_TAILS-1:0]     out_addr,
    output logic [DATA_INDEX_WIDTH-1:0] out_value,
    output logic [DATA_INDEX_WIDTH-1:0] out_count,
    output logic                        out_last,
    output logic                        scan_done,
    output logic                        wr_drop
);

    localparam int DW     = DATA_INDEX_WIDTH;
    localparam int ADDR_W = BIT_ON_TAILS + 1;
    localparam int DEPTH  = 1 << BIT_ON_TAILS;
    localparam int PTR_W  = hts_log2(DEPTH);
    localparam logic [PTR_W-1:0]  PTR_ONE    = 1;
    localparam logic [ADDR_W-1:0] REMAIN_ONE = 1;

    scan_state_t       r_state;
    logic [PTR_W-1:0]  r_ptr;
    logic [ADDR_W-1:0] r_remain;
    logic              r_busy;
    logic              r_out_valid;
    logic [PTR_W-1:0]  r_out_addr;
    logic [DW-1:0]     r_out_value;
    logic [DW-1:0]     r_out_count;
    logic              r_out_last;
    logic              r_scan_done;
    logic              r_wr_drop;

    logic [ADDR_W-1:0] w_ptr_addr;
    logic [ADDR_W-1:0] w_raddr;
    logic [ADDR_W-1:0] w_waddr;
    logic              w_we;
    logic              w_clr;
    logic [DW-1:0]     w_wr_hash;
    logic [DW-1:0]     w_wr_occ;
    logic [DW-1:0]     w_rd_hash;
    logic [DW-1:0]     w_rd_occ;
    logic [ADDR_W-1:0] w_qual_cnt;
    logic              w_qual;
    logic              w_ptr_last;

    assign w_ptr_addr = {1'b0, r_ptr};
    assign w_qual     = (w_rd_occ >= DW'(MIN_OCCURR));
    assign w_ptr_last = (r_ptr == '1);

    // While scanning, the scan pointer owns both table ports
    assign w_raddr = r_busy ? w_ptr_addr : HashOccurrAddr;
    assign w_waddr = r_busy ? w_ptr_addr : HashOccurrAddr;

`ifdef HASH_SCAN_CLEAR_EN
    // Zero the visited entry on every advance so the table is empty after the scan
    assign w_clr = r_busy && (((r_state == S_CHK) && !w_qual) ||
                              ((r_state == S_EMIT) && out_ready));
`else
    assign w_clr = 1'b0;
`endif

    assign w_we      = (WrEn && !r_busy) || w_clr;
    assign w_wr_hash = r_busy ? '0 : NewHashValue;
    assign w_wr_occ  = r_busy ? '0 : NewOccurrValue;

    hash_occurr_ram #(
        .DW         (DW),
        .AW         (BIT_ON_TAILS),
        .MIN_OCCURR (MIN_OCCURR)
    ) u_ram (
        .clk        (clk),
        .rst        (rst),
        .i_we       (w_we),
        .i_waddr    (w_waddr),
        .i_wr_hash  (w_wr_hash),
        .i_wr_occ   (w_wr_occ),
        .i_rd_addr  (w_raddr),
        .o_rd_hash  (w_rd_hash),
        .o_rd_occ   (w_rd_occ),
        .o_qual_cnt (w_qual_cnt)
    );

    // Scan FSM: walk every address, emit qualifying entries, flag the last via the precount
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_ptr       <= '0;
            r_remain    <= '0;
            r_busy      <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_addr  <= '0;
            r_out_value <= '0;
            r_out_count <= '0;
            r_out_last  <= 1'b0;
            r_scan_done <= 1'b0;
        end else begin
            r_scan_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (complete) begin
                        r_ptr    <= '0;
                        r_remain <= w_qual_cnt;
                        r_busy   <= 1'b1;
                        r_state  <= S_RD;
                    end
                end
                S_RD: begin
                    r_state <= S_CHK;
                end
                S_CHK: begin
                    if (w_qual) begin
                        r_out_valid <= 1'b1;
                        r_out_addr  <= r_ptr;
                        r_out_value <= w_rd_hash;
                        r_out_count <= w_rd_occ;
                        r_out_last  <= (r_remain == REMAIN_ONE);
                        r_state     <= S_EMIT;
                    end else if (w_ptr_last) begin
                        r_state <= S_DONE;
                    end else begin
                        r_ptr   <= r_ptr + PTR_ONE;
                        r_state <= S_RD;
                    end
                end
                S_EMIT: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_out_last  <= 1'b0;
                        r_remain    <= r_remain - REMAIN_ONE;
                        if (w_ptr_last) begin
                            r_state <= S_DONE;
                        end else begin
                            r_ptr   <= r_ptr + PTR_ONE;
                            r_state <= S_RD;
                        end
                    end
                end
                S_DONE: begin
                    r_scan_done <= 1'b1;
                    r_busy      <= 1'b0;
                    r_state     <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Sticky record of any host write that arrived while the scan owned the table
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_drop <= 1'b0;
        end else if (WrEn && r_busy) begin
            r_wr_drop <= 1'b1;
        end
    end

    assign HashValue   = w_rd_hash;
    assign OccurrValue = w_rd_occ;
    assign busy        = r_busy;
    assign out_valid   = r_out_valid;
    assign out_addr    = r_out_addr;
    assign out_value   = r_out_value;
    assign out_count   = r_out_count;
    assign out_last    = r_out_last;
    assign scan_done   = r_scan_done;
    assign wr_drop     = r_wr_drop;

endmodule

// File: tb/tb_hash_table_scan.sv
// tb/tb_hash_table_scan.sv - self-checking bench for hash_table_scan
module tb_hash_table_scan;

`ifdef HASH_SCAN_CLEAR_EN
    localparam bit CLEAR_ON = 1'b1;
`else
    localparam bit CLEAR_ON = 1'b0;
`endif

    localparam int DEPTH = 128;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  HashOccurrAddr = '0;
    logic [31:0] HashValue;
    logic [31:0] OccurrValue;
    logic        WrEn = 1'b0;
    logic [31:0] NewHashValue = '0;
    logic [31:0] NewOccurrValue = '0;
    logic        complete = 1'b0;
    logic        busy;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [6:0]  out_addr;
    logic [31:0] out_value;
    logic [31:0] out_count;
    logic        out_last;
    logic        scan_done;
    logic        wr_drop;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [7:0]  addr;
        logic [31:0] hash;
        logic [31:0] occ;
        logic [31:0] exp_hash;
        logic [31:0] exp_occ;
    } vec_t;

    typedef struct {
        logic [6:0]  addr;
        logic [31:0] value;
        logic [31:0] count;
        logic        last;
    } emit_t;

    vec_t  vecs [6];
    emit_t sb [$];

    hash_table_scan dut (
        .clk            (clk),
        .rst            (rst),
        .HashOccurrAddr (HashOccurrAddr),
        .HashValue      (HashValue),
        .OccurrValue    (OccurrValue),
        .WrEn           (WrEn),
        .NewHashValue   (NewHashValue),
        .NewOccurrValue (NewOccurrValue),
        .complete       (complete),
        .busy           (busy),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_addr       (out_addr),
        .out_value      (out_value),
        .out_count      (out_count),
        .out_last       (out_last),
        .scan_done      (scan_done),
        .wr_drop        (wr_drop)
    );

    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] h, input logic [31:0] c);
        HashOccurrAddr = a;
        NewHashValue   = h;
        NewOccurrValue = c;
        WrEn = 1'b1;
        @(negedge clk);
        WrEn = 1'b0;
    endtask

    task automatic rd_check(input string name, input logic [7:0] a,
                            input logic [31:0] eh, input logic [31:0] eo);
        HashOccurrAddr = a;
        @(negedge clk);
        check({name, "_hash"}, HashValue, eh);
        check({name, "_occ"}, OccurrValue, eo);
    endtask

    // Pulse complete and drain emits against the scoreboard; optionally stall the first emit
    task automatic run_scan(input string tag, input int stall, input bit do_drop);
        int    cyc;
        int    bad;
        bit    done;
        bit    stalled;
        emit_t e;
        logic [70:0] snap;
        out_ready = (stall == 0);
        complete = 1'b1;
        @(negedge clk);
        complete = 1'b0;
        cyc = 0;
        done = 1'b0;
        stalled = 1'b0;
        while (!done && cyc < 3000) begin
            if (out_valid && !out_ready && !stalled) begin
                snap = {out_addr, out_value, out_count, out_last};
                bad = 0;
                for (int i = 0; i < stall; i++) begin
                    if (do_drop && i == 3) begin
                        HashOccurrAddr = 8'd2;
                        NewHashValue   = 32'hDEAD;
                        NewOccurrValue = 32'd7;
                        WrEn = 1'b1;
                    end
                    @(negedge clk);
                    WrEn = 1'b0;
                    if (!out_valid || !busy || ({out_addr, out_value, out_count, out_last} != snap))
                        bad++;
                end
                check({tag, "_stall_stable"}, bad, 0);
                stalled = 1'b1;
                out_ready = 1'b1;
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    check({tag, "_extra_emit"}, out_addr, 7'h7F);
                end else begin
                    e = sb.pop_front();
                    check({tag, "_addr"}, out_addr, e.addr);
                    check({tag, "_value"}, out_value, e.value);
                    check({tag, "_count"}, out_count, e.count);
                    check({tag, "_last"}, out_last, e.last);
                end
            end
            if (scan_done) begin
                done = 1'b1;
                check({tag, "_busy_at_done"}, busy, 1'b0);
            end else begin
                @(negedge clk);
                cyc++;
            end
        end
        check({tag, "_scan_done_seen"}, done, 1'b1);
        check({tag, "_sb_empty"}, sb.size(), 0);
        out_ready = 1'b0;
        sb.delete();
    endtask

    initial begin
        int  n;
        bit  seen_valid;

        vecs[0] = '{8'd5,   32'hAB,        32'd3,        32'hAB,        32'd3};
        vecs[1] = '{8'd0,   32'h1234_5678, 32'd0,        32'h1234_5678, 32'd0};
        vecs[2] = '{8'd127, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        vecs[3] = '{8'd128, 32'hCAFE,      32'd9,        32'd0,         32'd0};
        vecs[4] = '{8'd255, 32'hBEEF,      32'd2,        32'd0,         32'd0};
        vecs[5] = '{8'd5,   32'h77,        32'd1,        32'h77,        32'd1};

        // Reset state
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_busy", busy, 1'b0);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_last", out_last, 1'b0);
        check("rst_scan_done", scan_done, 1'b0);
        check("rst_wr_drop", wr_drop, 1'b0);
        check("rst_out_data", {out_addr, out_value, out_count}, 71'd0);
        check("rst_hash", HashValue, 32'd0);
        check("rst_occ", OccurrValue, 32'd0);

        // Write vectors: write-first on the write edge, then a plain one-cycle read
        for (int i = 0; i < 6; i++) begin
            wr(vecs[i].addr, vecs[i].hash, vecs[i].occ);
            check($sformatf("wfirst%0d_hash", i), HashValue, vecs[i].exp_hash);
            check($sformatf("wfirst%0d_occ", i), OccurrValue, vecs[i].exp_occ);
            HashOccurrAddr = 8'd3;
            @(negedge clk);
            rd_check($sformatf("rd%0d", i), vecs[i].addr, vecs[i].exp_hash, vecs[i].exp_occ);
        end
        rd_check("alias0", 8'd0, 32'h1234_5678, 32'd0);
        rd_check("alias127", 8'd127, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        check("no_drop_idle", wr_drop, 1'b0);

        // Two-entry scan, ready held high
        do_reset();
        wr(8'd2, 32'h1111_0002, 32'd1);
        wr(8'd9, 32'h9999_0009, 32'd4);
        sb.push_back('{7'd2, 32'h1111_0002, 32'd1, 1'b0});
        sb.push_back('{7'd9, 32'h9999_0009, 32'd4, 1'b1});
        run_scan("scan2", 0, 1'b0);
        rd_check("post_scan2", 8'd2, CLEAR_ON ? 32'd0 : 32'h1111_0002, CLEAR_ON ? 32'd0 : 32'd1);
        rd_check("post_scan9", 8'd9, CLEAR_ON ? 32'd0 : 32'h9999_0009, CLEAR_ON ? 32'd0 : 32'd4);

        // Same table, stalled first emit with a write attempted while busy
        wr(8'd2, 32'h1111_0002, 32'd1);
        wr(8'd9, 32'h9999_0009, 32'd4);
        sb.push_back('{7'd2, 32'h1111_0002, 32'd1, 1'b0});
        sb.push_back('{7'd9, 32'h9999_0009, 32'd4, 1'b1});
        run_scan("stall", 10, 1'b1);
        check("wr_drop_set", wr_drop, 1'b1);
        rd_check("drop_addr2", 8'd2, CLEAR_ON ? 32'd0 : 32'h1111_0002, CLEAR_ON ? 32'd0 : 32'd1);

        // Empty table: scan_done exactly 2*depth+1 cycles after start, complete ignored mid-scan
        do_reset();
        complete = 1'b1;
        @(negedge clk);
        complete = 1'b0;
        n = 0;
        seen_valid = 1'b0;
        while (!scan_done && n < 1000) begin
            if (n == 50) complete = 1'b1;
            @(negedge clk);
            complete = 1'b0;
            if (out_valid) seen_valid = 1'b1;
            n++;
        end
        check("empty_done_latency", n, 2 * DEPTH + 1);
        check("empty_no_emit", seen_valid, 1'b0);
        @(negedge clk);
        check("done_one_cycle", scan_done, 1'b0);
        @(negedge clk);
        @(negedge clk);
        check("no_restart_busy", busy, 1'b0);

        // Every entry qualifies: precount must not wrap, last flag only on the final emit
        do_reset();
        for (int i = 0; i < DEPTH; i++) begin
            wr(8'(i), 32'(i * 3 + 1), 32'(i % 5 + 1));
            sb.push_back('{7'(i), 32'(i * 3 + 1), 32'(i % 5 + 1), (i == DEPTH - 1)});
        end
        run_scan("full", 0, 1'b0);

        // Asynchronous reset in the middle of an emit
        do_reset();
        wr(8'd2, 32'h1111_0002, 32'd1);
        wr(8'd9, 32'h9999_0009, 32'd4);
        out_ready = 1'b0;
        complete = 1'b1;
        @(negedge clk);
        complete = 1'b0;
        n = 0;
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("mid_emit_reached", out_valid, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        check("async_out_valid", out_valid, 1'b0);
        check("async_busy", busy, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        rd_check("rst_clear9", 8'd9, 32'd0, 32'd0);
        rd_check("rst_clear2", 8'd2, 32'd0, 32'd0);
        seen_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (out_valid || busy) seen_valid = 1'b1;
        end
        check("no_emit_after_rst", seen_valid, 1'b0);
        out_ready = 1'b0;

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
